// File: rtl/piece_queue_scheduler_if.sv
// Handshake bundle between the piece queue, its RNG and the game/preview consumers.
// The slave modport is the queue's view; the master modport is the surrounding logic.
interface piece_queue_scheduler_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                     flush;
  logic                     piece_pop;
  logic [2:0]               rng_num;
  logic                     rng_step;
  logic                     piece_valid;
  logic [2:0]               piece_id;
  logic [3*(DEPTH-1)-1:0]   preview;
  logic [CW-1:0]            count;
  logic                     busy;

  modport master (
    output flush, piece_pop, rng_num,
    input  rng_step, piece_valid, piece_id, preview, count, busy
  );

  modport slave (
    input  flush, piece_pop, rng_num,
    output rng_step, piece_valid, piece_id, preview, count, busy
  );
endinterface

// File: rtl/piece_queue_scheduler.sv
// Keeps a DEPTH-entry queue of tetromino IDs filled from a 3-bit RNG, one request in flight.
// Define NO_REPEAT_EN to reroll once when a candidate repeats the last pushed piece.
module piece_queue_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RNG_LAT = 3
) (
  input logic                    Clk,
  input logic                    Reset_n,
  piece_queue_scheduler_if.slave bus
);
  localparam int unsigned   CW        = $clog2(DEPTH + 1);
  localparam int unsigned   WW        = $clog2(RNG_LAT);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RNG_LAT - 2);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [1:0] {IDLE, STEP, WAIT, CHECK} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    q     [DEPTH];
  logic [2:0]    q_nxt [DEPTH];
  logic [CW-1:0] cnt, cnt_nxt, push_idx;
  logic          pop_ok;
  logic          push;
  logic [2:0]    cand;

`ifdef NO_REPEAT_EN
  logic [2:0]    last_piece;
  logic          reroll_done;
  logic          reroll_set;
`endif

  assign pop_ok = bus.piece_pop && (cnt != '0);
  assign cand   = bus.rng_num - 3'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= bus.flush ? IDLE : state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + WAIT_ONE : '0;
    end
  end

  // The STEP cycle plus RNG_LAT-1 WAIT cycles puts the CHECK sample RNG_LAT cycles after the pulse.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
`ifdef NO_REPEAT_EN
    reroll_set = 1'b0;
`endif
    case (state)
      IDLE:  if ((cnt < FULL) || pop_ok) state_nxt = STEP;
      STEP:  state_nxt = WAIT;
      WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = CHECK;
      CHECK: begin
        if (bus.rng_num == 3'd0) begin
          state_nxt = STEP;
`ifdef NO_REPEAT_EN
        end else if ((cand == last_piece) && !reroll_done) begin
          state_nxt  = STEP;
          reroll_set = 1'b1;
`endif
        end else begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slots at or above count are kept zero (pop shifts in zero, flush clears),
  // so head and preview need no masking against count.
  always_comb begin
    q_nxt = q;
    if (pop_ok) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) q_nxt[i] = q[i+1];
      q_nxt[DEPTH-1] = '0;
    end
    push_idx = pop_ok ? cnt - CNT_ONE : cnt;
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (CW'(i) == push_idx) q_nxt[i] = cand;
    end
    cnt_nxt = cnt;
    if (push && !pop_ok)      cnt_nxt = cnt + CNT_ONE;
    else if (pop_ok && !push) cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      cnt <= cnt_nxt;
      q   <= q_nxt;
    end
  end

`ifdef NO_REPEAT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_piece  <= 3'd7;
      reroll_done <= 1'b0;
    end else if (bus.flush) begin
      last_piece  <= 3'd7;
      reroll_done <= 1'b0;
    end else if (push) begin
      last_piece  <= cand;
      reroll_done <= 1'b0;
    end else if (reroll_set) begin
      reroll_done <= 1'b1;
    end
  end
`endif

  always_comb begin
    bus.preview = '0;
    for (int unsigned i = 1; i < DEPTH; i++) bus.preview[3*(i-1) +: 3] = q[i];
  end

  assign bus.piece_id    = q[0];
  assign bus.piece_valid = (cnt != '0);
  assign bus.count       = cnt;
  assign bus.rng_step    = (state == STEP);
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_piece_queue_scheduler.sv
// Directed bench for piece_queue_scheduler (DEPTH=4, RNG_LAT=3) with a behavioural RNG
// that replays either the 7-step LFSR order or a stub table of values.
module tb_piece_queue_scheduler;
  logic clk;
  logic rst_n;

  piece_queue_scheduler_if #(.DEPTH(4)) bus ();

  piece_queue_scheduler #(.DEPTH(4), .RNG_LAT(3)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // RNG model: each rng_step pulse loads the next value, visible from the following edge
  logic [2:0] seq  [7];
  logic [2:0] stub [8];
  int         stub_len;
  bit         stub_mode;
  int         ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 0;
      bus.rng_num <= 3'd0;
    end else if (bus.rng_step) begin
      if (stub_mode) bus.rng_num <= stub[(ptr < stub_len) ? ptr : stub_len - 1];
      else           bus.rng_num <= seq[ptr % 7];
      ptr <= ptr + 1;
    end
  end

  typedef struct {
    int unsigned cycles;
    logic        pop;
    logic        flush;
    logic [2:0]  count;
    logic        valid;
    logic [2:0]  id;
    logic [8:0]  preview;
    logic        busy;
    logic        step;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] snap();
    return {bus.count, bus.piece_valid, bus.piece_id, bus.preview, bus.busy, bus.rng_step};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.piece_pop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_stub(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input logic [2:0] d, input int len);
    stub_mode = 1'b1;
    stub[0] = a; stub[1] = b; stub[2] = c; stub[3] = d;
    stub_len = len;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int          pulses;
    int          seen;
    logic [2:0]  ids [5];
    logic [2:0]  exp_ids [5];
    logic [2:0]  maxc;
    logic [17:0] expv;
    bit          done;

    seq[0] = 3'd5; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd4;
    seq[4] = 3'd3; seq[5] = 3'd6; seq[6] = 3'd7;
    exp_ids[0] = 3'd4; exp_ids[1] = 3'd0; exp_ids[2] = 3'd1; exp_ids[3] = 3'd3; exp_ids[4] = 3'd2;
    stub_mode = 1'b0;
    stub_len  = 1;
    for (int i = 0; i < 8; i++) stub[i] = 3'd0;

    // cycles, pop, flush, count, valid, id, preview {e3,e2,e1} in octal, busy, rng_step
    vecs[0]  = '{5,  1'b0, 1'b0, 3'd1, 1'b1, 3'd4, 9'o000, 1'b0, 1'b0};
    vecs[1]  = '{5,  1'b0, 1'b0, 3'd2, 1'b1, 3'd4, 9'o000, 1'b0, 1'b0};
    vecs[2]  = '{5,  1'b0, 1'b0, 3'd3, 1'b1, 3'd4, 9'o010, 1'b0, 1'b0};
    vecs[3]  = '{5,  1'b0, 1'b0, 3'd4, 1'b1, 3'd4, 9'o310, 1'b0, 1'b0};
    vecs[4]  = '{10, 1'b0, 1'b0, 3'd4, 1'b1, 3'd4, 9'o310, 1'b0, 1'b0};
    vecs[5]  = '{1,  1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 9'o031, 1'b1, 1'b1};
    vecs[6]  = '{4,  1'b0, 1'b0, 3'd4, 1'b1, 3'd0, 9'o231, 1'b0, 1'b0};
    vecs[7]  = '{5,  1'b1, 1'b0, 3'd4, 1'b1, 3'd1, 9'o523, 1'b0, 1'b0};
    vecs[8]  = '{5,  1'b1, 1'b0, 3'd4, 1'b1, 3'd3, 9'o652, 1'b0, 1'b0};
    vecs[9]  = '{5,  1'b1, 1'b0, 3'd4, 1'b1, 3'd2, 9'o465, 1'b0, 1'b0};
    vecs[10] = '{5,  1'b1, 1'b0, 3'd4, 1'b1, 3'd5, 9'o046, 1'b0, 1'b0};
    vecs[11] = '{5,  1'b1, 1'b0, 3'd4, 1'b1, 3'd6, 9'o104, 1'b0, 1'b0};
    vecs[12] = '{5,  1'b1, 1'b0, 3'd4, 1'b1, 3'd4, 9'o310, 1'b0, 1'b0};
    vecs[13] = '{1,  1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 9'o000, 1'b0, 1'b0};
    vecs[14] = '{5,  1'b0, 1'b0, 3'd1, 1'b1, 3'd2, 9'o000, 1'b0, 1'b0};

    // Reset state, then the table against the real LFSR order
    rst_n = 1'b0; bus.flush = 1'b0; bus.piece_pop = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(snap()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.piece_pop = vecs[i].pop;
      bus.flush     = vecs[i].flush;
      tick();
      bus.piece_pop = 1'b0;
      bus.flush     = 1'b0;
      for (int unsigned c = 1; c < vecs[i].cycles; c++) tick();
      expv = {vecs[i].count, vecs[i].valid, vecs[i].id, vecs[i].preview, vecs[i].busy, vecs[i].step};
      check($sformatf("vec%0d", i), 32'(snap()), 32'(expv));
    end

    // Pop every cycle from reset: queue never holds more than one piece, order preserved
    do_reset();
    bus.piece_pop = 1'b1;
    seen = 0;
    maxc = 3'd0;
    for (int c = 0; c < 40; c++) begin
      if (bus.count > maxc) maxc = bus.count;
      if (bus.piece_valid && seen < 5) begin
        ids[seen] = bus.piece_id;
        seen++;
      end
      tick();
    end
    bus.piece_pop = 1'b0;
    check("popall_max_count", 32'(maxc), 32'd1);
    check("popall_seen", 32'(seen), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < seen) check($sformatf("popall_id%0d", i), 32'(ids[i]), 32'(exp_ids[i]));

    // rng_num==0 three times: three reroll pulses, then piece 5
    set_stub(3'd0, 3'd0, 3'd0, 3'd6, 4);
    do_reset();
    pulses = 0;
    first  = -1;
    done   = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bus.rng_step) pulses++;
      if (bus.piece_valid) begin
        first = c;
        check("zero_first_id", 32'(bus.piece_id), 32'd5);
        done = 1'b1;
      end else begin
        tick();
      end
    end
    check("zero_first_cycle", 32'(first), 32'd17);
    check("zero_pulses", 32'(pulses), 32'd4);

    // Repeated candidate 3,3,3
    set_stub(3'd3, 3'd3, 3'd3, 3'd3, 3);
    do_reset();
    pulses = 0;
    first  = -1;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.count == 3'd2) begin
        first = c;
        done  = 1'b1;
      end else begin
        if (bus.rng_step) pulses++;
        tick();
      end
    end
    check("repeat_head", 32'(bus.piece_id), 32'd2);
    check("repeat_entry1", 32'(bus.preview[2:0]), 32'd2);
`ifdef NO_REPEAT_EN
    check("repeat_pulses", 32'(pulses), 32'd3);
    check("repeat_cycle", 32'(first), 32'd14);
`else
    check("repeat_pulses", 32'(pulses), 32'd2);
    check("repeat_cycle", 32'(first), 32'd10);
`endif

    // flush with pop while the second request is in WAIT
    set_stub(3'd5, 3'd2, 3'd7, 3'd7, 3);
    do_reset();
    repeat (7) tick();
    check("flush_pre_count", 32'(bus.count), 32'd1);
    check("flush_pre_busy", 32'(bus.busy), 32'd1);
    bus.flush     = 1'b1;
    bus.piece_pop = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.piece_pop = 1'b0;
    check("flush_after", 32'({bus.count, bus.piece_valid, bus.piece_id, bus.busy}), 32'd0);
    repeat (4) tick();
    check("flush_still_empty", 32'(bus.count), 32'd0);
    tick();
    check("flush_refill", 32'({bus.count, bus.piece_id}), 32'({3'd1, 3'd6}));

    // Asynchronous reset in the middle of a fill
    stub_mode = 1'b0;
    do_reset();
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("reset_midfill", 32'(snap()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
